// File: rtl/quick_cpu_fetch.sv
// Program store and instruction fetch stage for the quick CPU core.
// Loads a byte program over a valid/ready port, then streams
// instructions with their PC to the core, with single-bubble jumps.
module quick_cpu_fetch #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             jump_valid,
  input  logic [AW-1:0]    jump_addr,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_data,
  output logic [AW-1:0]    inst_pc,
  output logic [AW:0]      prog_len,
  output logic             running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t           state_q, state_d;
  logic [AW:0]      len_q, len_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    ipc_q, ipc_d;
  logic             mem_we;
  logic [AW:0]      npc_w;
  logic [AW-1:0]    npc;
  logic [AW-1:0]    tgt;

  logic [WIDTH-1:0] mem [DEPTH];

  assign load_ready = (state_q == S_LOAD) && (len_q < FULL);
  assign inst_valid = valid_q;
  assign inst_data  = data_q;
  assign inst_pc    = ipc_q;
  assign prog_len   = len_q;
  assign running    = (state_q == S_RUN);

  // Sequential address wraps at the program length; the wide compare
  // also covers a full DEPTH-entry program, where it wraps naturally.
  assign npc_w = {1'b0, ipc_q} + ONE;
  assign npc   = (npc_w == len_q) ? '0 : npc_w[AW-1:0];
  assign tgt   = ({1'b0, jump_addr} < len_q) ? jump_addr : '0;

  // State register and fetch pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end

  // Program store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[len_q[AW-1:0]] <= load_data;
  end

  // Next-state and next-output logic.
  // In RUN, pc_q is only the pending fetch address used after a bubble;
  // while streaming, the next address comes from the presented inst_pc.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d = S_LOAD;
          len_d   = '0;
        end else if (len_q != '0) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_LOAD: begin
        if (load_valid && load_ready) begin
          mem_we = 1'b1;
          len_d  = len_q + ONE;
        end
        if (!load_en) state_d = S_IDLE;
      end
      S_RUN: begin
        if (load_en) begin
          state_d = S_LOAD;
          len_d   = '0;
          valid_d = 1'b0;
        end else if (jump_valid) begin
          valid_d = 1'b0;
          pc_d    = tgt;
        end else if (!valid_q) begin
          valid_d = 1'b1;
          ipc_d   = pc_q;
          data_d  = mem[pc_q];
        end else if (inst_ready) begin
          ipc_d  = npc;
          data_d = mem[npc];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_quick_cpu_fetch.sv
// Self-checking bench for quick_cpu_fetch: directed vector table,
// hand-written corner sequences, and randomized load/run against a
// queue-based program model.
module tb_quick_cpu_fetch;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_en = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready;
  logic             jump_valid = 1'b0;
  logic [AW-1:0]    jump_addr = '0;
  logic             inst_valid;
  logic             inst_ready = 1'b0;
  logic [WIDTH-1:0] inst_data;
  logic [AW-1:0]    inst_pc;
  logic [AW:0]      prog_len;
  logic             running;

  int n_chk  = 0;
  int n_fail = 0;

  quick_cpu_fetch #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .jump_valid(jump_valid),
    .jump_addr (jump_addr),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data (inst_data),
    .inst_pc   (inst_pc),
    .prog_len  (prog_len),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       le, lv;
    logic [7:0] ld;
    logic       jv;
    logic [3:0] ja;
    logic       ir;
    logic       ev;
    logic [3:0] epc;
    logic [7:0] ed;
    logic [4:0] elen;
    logic       erdy, erun;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic le, input logic lv, input logic [7:0] ld,
                     input logic jv, input logic [3:0] ja, input logic ir,
                     input logic ev, input logic [3:0] epc, input logic [7:0] ed,
                     input logic [4:0] elen, input logic erdy, input logic erun);
    vec_t v;
    v.le = le; v.lv = lv; v.ld = ld; v.jv = jv; v.ja = ja; v.ir = ir;
    v.ev = ev; v.epc = epc; v.ed = ed; v.elen = elen; v.erdy = erdy; v.erun = erun;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    load_en = 0; load_valid = 0; load_data = '0;
    jump_valid = 0; jump_addr = '0; inst_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #7;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int ev, epc, fetch, len_tgt, nrun;
    logic [7:0] q[$];

    // Reset state, sampled while reset is held
    idle_inputs();
    #3;
    chk("reset_valid", int'(inst_valid), 0);
    chk("reset_data", int'(inst_data), 0);
    chk("reset_pc", int'(inst_pc), 0);
    chk("reset_len", int'(prog_len), 0);
    chk("reset_ready", int'(load_ready), 0);
    chk("reset_running", int'(running), 0);
    #4 rst_n = 1;
    @(posedge clk); #1;

    // Directed table: le lv ld jv ja ir | ev epc ed elen erdy erun
    add(1,0,8'h00,0,0,0, 0,0,8'h00, 0,1,0);
    add(1,1,8'h11,0,0,0, 0,0,8'h00, 1,1,0);
    add(1,1,8'h22,0,0,0, 0,0,8'h00, 2,1,0);
    add(1,1,8'h33,0,0,0, 0,0,8'h00, 3,1,0);
    add(0,0,8'h00,0,0,0, 0,0,8'h00, 3,0,0);
    add(0,0,8'h00,0,0,1, 0,0,8'h00, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,0,8'h11, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,1,8'h22, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,2,8'h33, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,0,8'h11, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,1,8'h22, 3,0,1);
    for (int i = 0; i < 4; i++) add(0,0,8'h00,0,0,0, 1,1,8'h22, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,2,8'h33, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,0,8'h11, 3,0,1);
    add(0,0,8'h00,1,2,1, 0,0,8'h00, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,2,8'h33, 3,0,1);
    add(0,0,8'h00,1,7,1, 0,0,8'h00, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,0,8'h11, 3,0,1);
    add(0,0,8'h00,0,0,1, 1,1,8'h22, 3,0,1);
    add(1,0,8'h00,1,2,1, 0,0,8'h00, 0,1,0);
    add(1,1,8'hAA,1,1,1, 0,0,8'h00, 1,1,0);
    add(0,0,8'h00,0,0,1, 0,0,8'h00, 1,0,0);
    add(0,0,8'h00,0,0,1, 0,0,8'h00, 1,0,1);
    add(0,0,8'h00,0,0,1, 1,0,8'hAA, 1,0,1);
    add(0,0,8'h00,0,0,1, 1,0,8'hAA, 1,0,1);
    add(0,0,8'h00,0,0,0, 1,0,8'hAA, 1,0,1);

    foreach (tbl[i]) begin
      load_en = tbl[i].le; load_valid = tbl[i].lv; load_data = tbl[i].ld;
      jump_valid = tbl[i].jv; jump_addr = tbl[i].ja; inst_ready = tbl[i].ir;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), int'(inst_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i), int'(inst_pc), int'(tbl[i].epc));
        chk($sformatf("vec%0d_data", i), int'(inst_data), int'(tbl[i].ed));
      end
      chk($sformatf("vec%0d_len", i), int'(prog_len), int'(tbl[i].elen));
      chk($sformatf("vec%0d_ready", i), int'(load_ready), int'(tbl[i].erdy));
      chk($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].erun));
    end

    // Full load: 18 bytes offered, only 16 accepted; then wrap 15 -> 0
    do_reset();
    load_en = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      load_valid = 1; load_data = 8'(i);
      chk($sformatf("full_ready%0d", i), int'(load_ready), (i < 16) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk("full_len", int'(prog_len), 16);
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("full_running", int'(running), 1);
    chk("full_first_bubble", int'(inst_valid), 0);
    inst_ready = 1;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      chk($sformatf("full_pc%0d", i), int'(inst_pc), i % 16);
      chk($sformatf("full_data%0d", i), int'(inst_data), i % 16);
    end

    // Asynchronous reset between clock edges
    #3 rst_n = 0;
    #1;
    chk("async_valid", int'(inst_valid), 0);
    chk("async_running", int'(running), 0);
    chk("async_len", int'(prog_len), 0);
    #2 rst_n = 1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("after_reset_stays_idle", int'(running), 0);

    // Randomized load and run against a queue model of the program
    for (int t = 0; t < 12; t++) begin
      do_reset();
      q.delete();
      len_tgt = $urandom_range(1, DEPTH);
      load_en = 1;
      @(posedge clk); #1;
      for (int c = 0; c < 40; c++) begin
        load_valid = (q.size() < len_tgt || len_tgt == DEPTH) ? 1'($urandom % 2) : 1'b0;
        load_data  = 8'($urandom);
        chk("rnd_load_ready", int'(load_ready), (q.size() < DEPTH) ? 1 : 0);
        @(posedge clk);
        if (load_valid && q.size() < DEPTH) q.push_back(load_data);
        #1;
        chk("rnd_len", int'(prog_len), q.size());
      end
      if (q.size() == 0) begin
        load_valid = 1; load_data = 8'($urandom);
        @(posedge clk);
        q.push_back(load_data);
        #1;
      end
      idle_inputs();
      @(posedge clk); #1;
      chk("rnd_idle_running", int'(running), 0);
      @(posedge clk); #1;
      chk("rnd_run_running", int'(running), 1);
      chk("rnd_run_bubble", int'(inst_valid), 0);
      ev = 0; epc = 0; fetch = 0;
      nrun = q.size();
      for (int c = 0; c < 60; c++) begin
        inst_ready = ($urandom % 4) != 0;
        jump_valid = ($urandom % 8) == 0;
        jump_addr  = 4'($urandom);
        @(posedge clk);
        if (jump_valid) begin
          ev = 0;
          fetch = (int'(jump_addr) < nrun) ? int'(jump_addr) : 0;
        end else if (ev == 0) begin
          ev = 1;
          epc = fetch;
        end else if (inst_ready) begin
          epc = (epc + 1) % nrun;
        end
        #1;
        chk("rnd_valid", int'(inst_valid), ev);
        chk("rnd_running", int'(running), 1);
        if (ev != 0) begin
          chk("rnd_pc", int'(inst_pc), epc);
          chk("rnd_data", int'(inst_data), int'(q[epc]));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
